uart_interface: RTL and testbench
=================================

# uart_interface

Byte-to-word bridge between the UART (`receiver`/`transmitter` pair) and the BIP core. It assembles 3-byte command frames from the receiver into one opcode/operand command for the BIP. It also serializes 16-bit BIP responses into two bytes through the transmitter using its `tx_start`/`tx_done` handshake. It sits between the UART top's `uart_to_bip`/`rx_done`/`bip_to_uart`/`tx_start`/`tx_done` ports and the BIP.

## Interface
- `TIMEOUT_CYCLES`, default 1000000: inter-byte timeout in clk cycles. Range 2..2^24-1. Used only with `UART_IF_TIMEOUT_EN`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_done` in 1: one-cycle pulse, receiver byte valid.
- `rx_data` in 8: receiver byte, valid when `rx_done`=1.
- `tx_done` in 1: one-cycle pulse from transmitter at end of stop bit.
- `tx_start` out 1: one-cycle pulse, start transmitting `tx_data`.
- `tx_data` out 8: byte to transmitter.
- `cmd_valid` out 1: command frame available.
- `cmd_ready` in 1: BIP accepts command.
- `cmd_opcode` out 8: frame byte 0.
- `cmd_data` out 16: {byte 2, byte 1}, little-endian.
- `rsp_valid` in 1: BIP response available.
- `rsp_ready` out 1: interface accepts response.
- `rsp_data` in 16: response word.
- `overrun` out 1: sticky; a byte was dropped.
- `frame_err` out 1: one-cycle pulse when a partial frame is discarded on timeout.

## Operation
- **RX FSM** states RX_OP → RX_LO → RX_HI → RX_HOLD.
  - Each `rx_done` in RX_OP/RX_LO/RX_HI latches `rx_data` into opcode, data[7:0] or data[15:8] respectively, then advances.
  - RX_HI + `rx_done` → RX_HOLD, with `cmd_valid`=1.
- **RX_HOLD**
  - Outputs are stable until `cmd_valid & cmd_ready`, which returns the FSM to RX_OP.
  - `rx_done` without `cmd_ready`: byte dropped, `overrun` set. `overrun` clears only on reset.
  - `rx_done` and `cmd_ready` in the same cycle: handshake completes, the byte is latched as the new opcode, and the FSM goes to RX_LO.
- **TX FSM** states TX_IDLE → TX_LO → TX_WAIT_LO → TX_HI → TX_WAIT_HI → TX_IDLE.
  - `rsp_ready`=1 only in TX_IDLE. `rsp_valid & rsp_ready` latches `rsp_data`.
  - TX_LO: `tx_data`=word[7:0], `tx_start`=1 for one cycle.
  - TX_WAIT_LO: waits for `tx_done`.
  - TX_HI/TX_WAIT_HI: same sequence for word[15:8].
  - `tx_done` outside the WAIT states is ignored.
- The RX and TX FSMs are fully independent. Simultaneous RX and TX activity is legal.
- **Reset values** (`reset`=0, asynchronous): both FSMs idle, `cmd_valid`=0, `cmd_opcode`=0, `cmd_data`=0, `rsp_ready`=0, `tx_start`=0, `tx_data`=0, `overrun`=0, `frame_err`=0.
  - Partial frames and in-flight responses are lost.
  - `rsp_ready` rises in the first cycle after reset deasserts.

## Timing
- `cmd_valid` rises on the clk edge following the third `rx_done`, so it is high 1 cycle after that pulse.
- Command handshake completes on the edge where `cmd_valid & cmd_ready`=1. `cmd_valid` is low the next cycle unless the same-cycle byte case applies, in which case it is also low.
- `tx_start` is high the cycle after response acceptance, and 1 cycle after the low-byte `tx_done` for the high byte.
- `tx_data` is valid from the `tx_start` cycle until that byte's `tx_done`.
- `rsp_ready` returns high the cycle after the high-byte `tx_done`.
- Minimum response turnaround is 2×(byte time) + 3 cycles.

## Configuration
- `UART_IF_TIMEOUT_EN` defined:
  - A 24-bit counter clears on every `rx_done` and while in RX_OP/RX_HOLD, and increments each cycle in RX_LO/RX_HI.
  - When the counter equals `TIMEOUT_CYCLES-1` and no `rx_done` occurs that cycle, the next edge sends the RX FSM to RX_OP, discards latched bytes, and pulses `frame_err` for 1 cycle.
  - `rx_done` on the expiry cycle wins: the byte is accepted and there is no timeout.
- `UART_IF_TIMEOUT_EN` undefined: no counter, `frame_err` tied 0, and a partial frame waits indefinitely.

## Test plan
- RX bytes 0x12, 0x34, 0x56 with `cmd_ready`=1 → `cmd_valid` high 1 cycle after the third `rx_done`, `cmd_opcode`=0x12, `cmd_data`=0x5634; back to RX_OP.
- Full frame with `cmd_ready`=0, then 0xAA arrives → byte dropped, `overrun`=1, outputs unchanged. Then `cmd_ready`=1 together with the 0x77 `rx_done` → 0x77 becomes the next opcode.
- `rsp_data`=0xBEEF with `rsp_valid`=1 → `tx_start` pulses with `tx_data`=0xEF, then after `tx_done` pulses with 0xBE; `rsp_ready` is low throughout and returns after the second `tx_done`.
- `UART_IF_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: send 0x01, then idle 100 cycles → `frame_err` pulse, next bytes 0x02, 0x03, 0x04 give opcode 0x02. Idle 99 cycles then a byte → no `frame_err`.
- Assert `reset`=0 mid-frame (after 1 byte) and mid-TX (TX_WAIT_HI) → all outputs at reset values immediately. After release, a fresh 3-byte frame decodes correctly.
- Concurrent: a 0x1234 response transmits while the frame 0x09, 0x0A, 0x0B is received → both complete correctly, with no interaction.

Source files
------------

// File: rtl/uart_interface_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_interface_if
// Description : Signal bundle between the UART byte ports, the BIP command
//               and response channels, and the uart_interface bridge.
//   Receiver side   : rx_done, rx_data
//   Transmitter side: tx_start, tx_data, tx_done
//   BIP command     : cmd_valid, cmd_ready, cmd_opcode, cmd_data
//   BIP response    : rsp_valid, rsp_ready, rsp_data
//   Status          : overrun (sticky), frame_err (pulse)
//   Modports        : slave  = bridge view, master = surrounding system view
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_interface_if;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        overrun;
  logic        frame_err;

  modport slave (
    input  rx_done, rx_data, tx_done, cmd_ready, rsp_valid, rsp_data,
    output tx_start, tx_data, cmd_valid, cmd_opcode, cmd_data, rsp_ready,
           overrun, frame_err
  );

  modport master (
    output rx_done, rx_data, tx_done, cmd_ready, rsp_valid, rsp_data,
    input  tx_start, tx_data, cmd_valid, cmd_opcode, cmd_data, rsp_ready,
           overrun, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_interface.sv
`default_nettype none
// ============================================================================
// Module      : uart_interface
// Description : Byte-to-word bridge between the UART and the BIP core.
//               RX path assembles 3-byte frames {opcode, lo, hi} into one
//               command; TX path splits a 16-bit response into two bytes
//               (low first) using the transmitter start/done handshake.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - uart_interface_if.slave (UART bytes, BIP cmd/rsp,
//                       overrun and frame_err status)
// Parameters  : TIMEOUT_CYCLES - inter-byte timeout in clk cycles (2..2^24-1)
// Config      : define UART_IF_TIMEOUT_EN to enable the inter-byte timeout;
//               otherwise frame_err is tied low and partial frames wait.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_interface #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  uart_interface_if.slave bus
);

  // --------------------------------------------------------------------------
  // RX frame assembly
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_OP   = 2'd0,
    RX_LO   = 2'd1,
    RX_HI   = 2'd2,
    RX_HOLD = 2'd3
  } rx_state_t;

  rx_state_t   r_rx_state, w_rx_next;
  logic [7:0]  r_opcode;
  logic [15:0] r_data;
  logic        r_overrun;
  logic        w_ld_op, w_ld_lo, w_ld_hi, w_set_ovr;
  logic        w_timeout;
  logic        w_frame_err;

  always_comb begin
    w_rx_next = r_rx_state;
    w_ld_op   = 1'b0;
    w_ld_lo   = 1'b0;
    w_ld_hi   = 1'b0;
    w_set_ovr = 1'b0;
    case (r_rx_state)
      RX_OP: begin
        if (bus.rx_done) begin
          w_ld_op   = 1'b1;
          w_rx_next = RX_LO;
        end
      end
      RX_LO: begin
        if (bus.rx_done) begin
          w_ld_lo   = 1'b1;
          w_rx_next = RX_HI;
        end else if (w_timeout) begin
          w_rx_next = RX_OP;
        end
      end
      RX_HI: begin
        if (bus.rx_done) begin
          w_ld_hi   = 1'b1;
          w_rx_next = RX_HOLD;
        end else if (w_timeout) begin
          w_rx_next = RX_OP;
        end
      end
      RX_HOLD: begin
        if (bus.cmd_ready) begin
          // A byte arriving on the handshake cycle starts the next frame.
          if (bus.rx_done) begin
            w_ld_op   = 1'b1;
            w_rx_next = RX_LO;
          end else begin
            w_rx_next = RX_OP;
          end
        end else if (bus.rx_done) begin
          w_set_ovr = 1'b1;
        end
      end
      default: w_rx_next = RX_OP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= RX_OP;
      r_opcode   <= 8'h00;
      r_data     <= 16'h0000;
      r_overrun  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_timeout) begin
        r_opcode <= 8'h00;
        r_data   <= 16'h0000;
      end else begin
        if (w_ld_op) r_opcode     <= bus.rx_data;
        if (w_ld_lo) r_data[7:0]  <= bus.rx_data;
        if (w_ld_hi) r_data[15:8] <= bus.rx_data;
      end
      if (w_set_ovr) r_overrun <= 1'b1;
    end
  end

`ifdef UART_IF_TIMEOUT_EN
  localparam logic [23:0] C_TO_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] r_to_cnt;
  logic        r_frame_err;
  logic        w_mid_frame;

  assign w_mid_frame = (r_rx_state == RX_LO) || (r_rx_state == RX_HI);
  // A byte on the expiry cycle takes priority over the timeout.
  assign w_timeout   = w_mid_frame && !bus.rx_done && (r_to_cnt == C_TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt    <= 24'd0;
      r_frame_err <= 1'b0;
    end else begin
      if (bus.rx_done || !w_mid_frame) r_to_cnt <= 24'd0;
      else                             r_to_cnt <= r_to_cnt + 24'd1;
      r_frame_err <= w_timeout;
    end
  end

  assign w_frame_err = r_frame_err;
`else
  assign w_timeout   = 1'b0;
  assign w_frame_err = 1'b0;
`endif

  assign bus.cmd_valid  = (r_rx_state == RX_HOLD);
  assign bus.cmd_opcode = r_opcode;
  assign bus.cmd_data   = r_data;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = w_frame_err;

  // --------------------------------------------------------------------------
  // TX response serializer
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_LO      = 3'd1,
    TX_WAIT_LO = 3'd2,
    TX_HI      = 3'd3,
    TX_WAIT_HI = 3'd4
  } tx_state_t;

  tx_state_t   r_tx_state, w_tx_next;
  logic [15:0] r_word;
  logic        r_rsp_en;
  logic        w_accept;
  logic        w_hi_phase;

  // Keeps rsp_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rsp_en <= 1'b0;
    else        r_rsp_en <= 1'b1;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_accept  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (bus.rsp_valid && r_rsp_en) begin
          w_accept  = 1'b1;
          w_tx_next = TX_LO;
        end
      end
      TX_LO:      w_tx_next = TX_WAIT_LO;
      TX_WAIT_LO: if (bus.tx_done) w_tx_next = TX_HI;
      TX_HI:      w_tx_next = TX_WAIT_HI;
      TX_WAIT_HI: if (bus.tx_done) w_tx_next = TX_IDLE;
      default:    w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= TX_IDLE;
      r_word     <= 16'h0000;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_accept) r_word <= bus.rsp_data;
    end
  end

  assign w_hi_phase    = (r_tx_state == TX_HI) || (r_tx_state == TX_WAIT_HI);
  assign bus.rsp_ready = (r_tx_state == TX_IDLE) && r_rsp_en;
  assign bus.tx_start  = (r_tx_state == TX_LO) || (r_tx_state == TX_HI);
  assign bus.tx_data   = w_hi_phase ? r_word[15:8] : r_word[7:0];

endmodule
`default_nettype wire

// File: tb/tb_uart_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_interface
// Description : Directed self-checking bench for uart_interface: frame
//               assembly, overrun, response serialization, timeout (when
//               UART_IF_TIMEOUT_EN is defined), asynchronous reset and
//               concurrent RX/TX traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_interface;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic saw_fe;

  uart_interface_if bus ();

  uart_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_valid"},  {31'd0, bus.cmd_valid},  32'd0);
    check({tag, "_cmd_opcode"}, {24'd0, bus.cmd_opcode}, 32'd0);
    check({tag, "_cmd_data"},   {16'd0, bus.cmd_data},   32'd0);
    check({tag, "_rsp_ready"},  {31'd0, bus.rsp_ready},  32'd0);
    check({tag, "_tx_start"},   {31'd0, bus.tx_start},   32'd0);
    check({tag, "_tx_data"},    {24'd0, bus.tx_data},    32'd0);
    check({tag, "_overrun"},    {31'd0, bus.overrun},    32'd0);
    check({tag, "_frame_err"},  {31'd0, bus.frame_err},  32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.tx_done   = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 16'h0000;

    // ---------------- reset state ----------------
    #2;
    check_reset_values("rst");
    tick();
    tick();
    reset = 1'b1;
    check("rsp_ready_at_release", {31'd0, bus.rsp_ready}, 32'd0);
    tick();
    check("rsp_ready_after_release", {31'd0, bus.rsp_ready}, 32'd1);

    // ---------------- basic frame ----------------
    bus.cmd_ready = 1'b1;
    send_byte(8'h12);
    check("f1_valid_after_b0", {31'd0, bus.cmd_valid}, 32'd0);
    send_byte(8'h34);
    send_byte(8'h56);
    check("f1_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("f1_opcode", {24'd0, bus.cmd_opcode}, 32'h12);
    check("f1_data",   {16'd0, bus.cmd_data},   32'h5634);
    tick();
    check("f1_valid_after_hs", {31'd0, bus.cmd_valid}, 32'd0);
    check("f1_overrun", {31'd0, bus.overrun}, 32'd0);

    // ---------------- overrun and same-cycle byte ----------------
    bus.cmd_ready = 1'b0;
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    check("f2_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("f2_opcode", {24'd0, bus.cmd_opcode}, 32'hA1);
    check("f2_data",   {16'd0, bus.cmd_data},   32'hC3B2);
    send_byte(8'hAA);
    check("ovr_set",    {31'd0, bus.overrun},    32'd1);
    check("ovr_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("ovr_opcode", {24'd0, bus.cmd_opcode}, 32'hA1);
    check("ovr_data",   {16'd0, bus.cmd_data},   32'hC3B2);
    bus.cmd_ready = 1'b1;
    send_byte(8'h77);
    bus.cmd_ready = 1'b0;
    check("same_valid",  {31'd0, bus.cmd_valid},  32'd0);
    check("same_opcode", {24'd0, bus.cmd_opcode}, 32'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    check("f3_valid",   {31'd0, bus.cmd_valid},  32'd1);
    check("f3_opcode",  {24'd0, bus.cmd_opcode}, 32'h77);
    check("f3_data",    {16'd0, bus.cmd_data},   32'h9988);
    check("ovr_sticky", {31'd0, bus.overrun},    32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("f3_valid_after_hs", {31'd0, bus.cmd_valid}, 32'd0);

    // ---------------- response serialization ----------------
    check("tx_ready_idle", {31'd0, bus.rsp_ready}, 32'd1);
    bus.rsp_data  = 16'hBEEF;
    bus.rsp_valid = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    check("tx_lo_start", {31'd0, bus.tx_start},  32'd1);
    check("tx_lo_data",  {24'd0, bus.tx_data},   32'hEF);
    check("tx_lo_ready", {31'd0, bus.rsp_ready}, 32'd0);
    tick();
    check("tx_lo_start_pulse", {31'd0, bus.tx_start}, 32'd0);
    check("tx_lo_data_hold",   {24'd0, bus.tx_data},  32'hEF);
    tick();
    tick();
    check("tx_wait_lo_ready", {31'd0, bus.rsp_ready}, 32'd0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("tx_hi_start", {31'd0, bus.tx_start},  32'd1);
    check("tx_hi_data",  {24'd0, bus.tx_data},   32'hBE);
    check("tx_hi_ready", {31'd0, bus.rsp_ready}, 32'd0);
    tick();
    check("tx_hi_start_pulse", {31'd0, bus.tx_start},  32'd0);
    check("tx_wait_hi_ready",  {31'd0, bus.rsp_ready}, 32'd0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("tx_done_ready", {31'd0, bus.rsp_ready}, 32'd1);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("tx_stray_done_start", {31'd0, bus.tx_start},  32'd0);
    check("tx_stray_done_ready", {31'd0, bus.rsp_ready}, 32'd1);

    // ---------------- inter-byte timeout ----------------
`ifdef UART_IF_TIMEOUT_EN
    bus.cmd_ready = 1'b0;
    send_byte(8'h01);
    saw_fe = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (bus.frame_err) saw_fe = 1'b1;
    end
    check("to_no_early_fe", {31'd0, saw_fe}, 32'd0);
    tick();
    check("to_fe_pulse", {31'd0, bus.frame_err}, 32'd1);
    tick();
    check("to_fe_one_cycle", {31'd0, bus.frame_err}, 32'd0);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check("to_f_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("to_f_opcode", {24'd0, bus.cmd_opcode}, 32'h02);
    check("to_f_data",   {16'd0, bus.cmd_data},   32'h0403);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    send_byte(8'h05);
    saw_fe = 1'b0;
    for (int i = 0; i < TO - 2; i++) begin
      tick();
      if (bus.frame_err) saw_fe = 1'b1;
    end
    send_byte(8'h06);
    if (bus.frame_err) saw_fe = 1'b1;
    tick();
    if (bus.frame_err) saw_fe = 1'b1;
    check("to_edge_no_fe", {31'd0, saw_fe}, 32'd0);
    send_byte(8'h07);
    check("to_edge_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("to_edge_opcode", {24'd0, bus.cmd_opcode}, 32'h05);
    check("to_edge_data",   {16'd0, bus.cmd_data},   32'h0706);
`else
    bus.cmd_ready = 1'b0;
    send_byte(8'h01);
    saw_fe = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (bus.frame_err) saw_fe = 1'b1;
    end
    check("nto_no_fe", {31'd0, saw_fe}, 32'd0);
    send_byte(8'h02);
    send_byte(8'h03);
    check("nto_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("nto_opcode", {24'd0, bus.cmd_opcode}, 32'h01);
    check("nto_data",   {16'd0, bus.cmd_data},   32'h0302);
`endif
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("pre_rst_idle", {31'd0, bus.cmd_valid}, 32'd0);

    // ---------------- asynchronous reset mid-frame / mid-TX ----------------
    send_byte(8'h55);
    bus.rsp_data  = 16'h1357;
    bus.rsp_valid = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    tick();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    check("mid_tx_data_hi", {24'd0, bus.tx_data}, 32'h13);
    reset = 1'b0;
    #1;
    check_reset_values("arst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    send_byte(8'h21);
    send_byte(8'h22);
    send_byte(8'h23);
    check("post_rst_valid",  {31'd0, bus.cmd_valid},  32'd1);
    check("post_rst_opcode", {24'd0, bus.cmd_opcode}, 32'h21);
    check("post_rst_data",   {16'd0, bus.cmd_data},   32'h2322);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;

    // ---------------- concurrent RX and TX ----------------
    bus.rsp_data  = 16'h1234;
    bus.rsp_valid = 1'b1;
    bus.rx_data   = 8'h09;
    bus.rx_done   = 1'b1;
    tick();
    bus.rsp_valid = 1'b0;
    bus.rx_done   = 1'b0;
    check("cc_lo_start", {31'd0, bus.tx_start}, 32'd1);
    check("cc_lo_data",  {24'd0, bus.tx_data},  32'h34);
    tick();
    send_byte(8'h0A);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("cc_hi_start", {31'd0, bus.tx_start}, 32'd1);
    check("cc_hi_data",  {24'd0, bus.tx_data},  32'h12);
    send_byte(8'h0B);
    check("cc_valid",    {31'd0, bus.cmd_valid},  32'd1);
    check("cc_opcode",   {24'd0, bus.cmd_opcode}, 32'h09);
    check("cc_data",     {16'd0, bus.cmd_data},   32'h0B0A);
    check("cc_hi_wait",  {31'd0, bus.tx_start},   32'd0);
    check("cc_hi_dhold", {24'd0, bus.tx_data},    32'h12);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("cc_rsp_ready", {31'd0, bus.rsp_ready}, 32'd1);
    check("cc_valid_kept", {31'd0, bus.cmd_valid}, 32'd1);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check("cc_valid_done", {31'd0, bus.cmd_valid}, 32'd0);
    check("cc_no_overrun", {31'd0, bus.overrun},   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
